// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC sequencer: FSM state encoding and datapath widths.
package mac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int ACC_W = 12;
  localparam int OP_W  = 4;
  localparam logic [ACC_W-1:0] ACC_MAX = 12'hFFF;

endpackage

// File: rtl/MAC_4bit.sv
// Combinational multiply-accumulate: {cout, sum} = c + a*b, product zero-extended.
module MAC_4bit
  import mac_pkg::*;
(
  input  logic [OP_W-1:0]  a,
  input  logic [OP_W-1:0]  b,
  input  logic [ACC_W-1:0] c,
  output logic [ACC_W-1:0] sum,
  output logic             cout
);

  logic [2*OP_W-1:0] prod;

  always_comb begin
    prod        = a * b;
    {cout, sum} = {1'b0, c} + {{(ACC_W-2*OP_W+1){1'b0}}, prod};
  end

endmodule

// File: rtl/mac_seq_ctrl.sv
// Job sequencer around one MAC_4bit: streams operand pairs into a 12-bit accumulator.
// Optional MAC_SEQ_SAT_EN: saturate the accumulator at ACC_MAX on carry-out instead of wrapping.
module mac_seq_ctrl
  import mac_pkg::*;
#(
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [ACC_W-1:0] bias,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_a,
  input  logic [OP_W-1:0]  in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W-1:0] mac_sum;
  logic             mac_cout;
  logic [ACC_W-1:0] step_acc;

  MAC_4bit u_mac (
    .a    (in_a),
    .b    (in_b),
    .c    (acc_q),
    .sum  (mac_sum),
    .cout (mac_cout)
  );

`ifdef MAC_SEQ_SAT_EN
  assign step_acc = mac_cout ? ACC_MAX : mac_sum;
`else
  assign step_acc = mac_sum;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        // abort in IDLE does nothing itself but still blocks a coincident start
        if (start && !abort) begin
          len_d   = len;
          acc_d   = bias;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = (len == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (in_valid) begin
          acc_d = step_acc;
          ovf_d = ovf_q | mac_cout;
          cnt_d = cnt_q + LEN_W'(1);
          if (cnt_q == len_q - LEN_W'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (abort || out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
    end
  end

  // Handshake outputs depend on registered state only
  assign in_ready  = (state_q == ST_RUN);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign out_acc   = acc_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Self-checking bench for mac_seq_ctrl: directed scenarios plus randomized jobs against a dot-product model.
module tb_mac_seq_ctrl;

  localparam int LEN_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [LEN_W-1:0] len;
  logic [11:0]      bias;
  logic             abort;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_a;
  logic [3:0]       in_b;
  logic             out_valid;
  logic             out_ready;
  logic [11:0]      out_acc;
  logic             out_ovf;
  logic             busy;

  int checks = 0;
  int errors = 0;

  logic [3:0]  pa [16];
  logic [3:0]  pb [16];
  logic [15:0] vpat;

  mac_seq_ctrl #(.LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .bias      (bias),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    check(tag, {11'b0, obs}, {11'b0, exp});
  endtask

  // Dot product of the first n pairs plus bias, with 12-bit wrap or saturation.
  function automatic void model(input logic [11:0] b, input int n,
                                output logic [11:0] acc, output logic ovf);
    int s;
    acc = b;
    ovf = 1'b0;
    for (int i = 0; i < n; i++) begin
      s = int'(acc) + int'(pa[i]) * int'(pb[i]);
      if (s > 4095) begin
        ovf = 1'b1;
`ifdef MAC_SEQ_SAT_EN
        acc = 12'hFFF;
`else
        acc = 12'(s - 4096);
`endif
      end else begin
        acc = 12'(s);
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: in_valid always high, 1: random, 2: pattern from vpat
  task automatic do_job(input string tag, input logic [11:0] b, input int n,
                        input int mode, input int hold);
    logic [11:0] ea;
    logic        eo;
    int          idx;
    int          guard;
    model(b, n, ea, eo);
    start = 1'b1;
    len   = LEN_W'(n);
    bias  = b;
    tick();
    start = 1'b0;
    len   = LEN_W'($urandom);
    bias  = 12'($urandom);
    if (n == 0) begin
      check1({tag, "_zl_in_ready"}, in_ready, 1'b0);
    end else begin
      idx   = 0;
      guard = 0;
      while (idx < n && guard < 200) begin
        check1({tag, "_in_ready"}, in_ready, 1'b1);
        check1({tag, "_run_out_valid"}, out_valid, 1'b0);
        case (mode)
          0:       in_valid = 1'b1;
          1:       in_valid = 1'($urandom_range(0, 1));
          default: in_valid = vpat[guard];
        endcase
        in_a = pa[idx];
        in_b = pb[idx];
        tick();
        if (in_valid) idx++;
        guard++;
      end
      in_valid = 1'b0;
      in_a     = 4'($urandom);
      in_b     = 4'($urandom);
      if (guard >= 200) check({tag, "_timeout"}, 12'(idx), 12'(n));
    end
    check1({tag, "_out_valid"}, out_valid, 1'b1);
    check1({tag, "_done_in_ready"}, in_ready, 1'b0);
    check1({tag, "_busy"}, busy, 1'b1);
    check({tag, "_out_acc"}, out_acc, ea);
    check1({tag, "_out_ovf"}, out_ovf, eo);
    for (int k = 0; k < hold; k++) begin
      out_ready = 1'b0;
      if (k == 1) begin
        start = 1'b1;
        len   = LEN_W'(3);
        bias  = 12'h000;
      end
      tick();
      start = 1'b0;
      check1({tag, "_hold_valid"}, out_valid, 1'b1);
      check({tag, "_hold_acc"}, out_acc, ea);
      check1({tag, "_hold_ovf"}, out_ovf, eo);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check1({tag, "_post_valid"}, out_valid, 1'b0);
    check1({tag, "_post_busy"}, busy, 1'b0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    len       = '0;
    bias      = '0;
    abort     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    vpat      = '0;
    tick();
    tick();
    check1("rst_in_ready", in_ready, 1'b0);
    check1("rst_out_valid", out_valid, 1'b0);
    check("rst_out_acc", out_acc, 12'h000);
    check1("rst_out_ovf", out_ovf, 1'b0);
    check1("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    tick();

    // Basic job
    pa[0] = 4'd3;  pb[0] = 4'd5;
    pa[1] = 4'd15; pb[1] = 4'd15;
    pa[2] = 4'd2;  pb[2] = 4'd7;
    do_job("basic", 12'h000, 3, 0, 0);

    // Overflow
    pa[0] = 4'd15; pb[0] = 4'd15;
    pa[1] = 4'd15; pb[1] = 4'd15;
    do_job("ovf", 12'hF00, 2, 0, 1);

    // Zero length
    do_job("zlen", 12'h123, 0, 0, 0);

    // Stalls, long DONE hold with an ignored start
    pa[0] = 4'd1; pb[0] = 4'd1;
    pa[1] = 4'd2; pb[1] = 4'd2;
    pa[2] = 4'd3; pb[2] = 4'd3;
    vpat  = 16'b11001;
    do_job("stall", 12'h000, 3, 2, 5);

    // Abort after two handshakes, coincident with a third pair
    start = 1'b1;
    len   = LEN_W'(4);
    bias  = 12'h010;
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    in_a = 4'd4; in_b = 4'd4;
    tick();
    tick();
    check1("abort_pre_busy", busy, 1'b1);
    abort = 1'b1;
    in_a  = 4'd9; in_b = 4'd9;
    tick();
    abort    = 1'b0;
    in_valid = 1'b0;
    check1("abort_busy", busy, 1'b0);
    check1("abort_out_valid", out_valid, 1'b0);
    check1("abort_in_ready", in_ready, 1'b0);
    tick();
    check1("abort_no_result", out_valid, 1'b0);
    pa[0] = 4'd2; pb[0] = 4'd3;
    do_job("after_abort", 12'h005, 1, 0, 0);

    // Reset mid-job
    start = 1'b1;
    len   = LEN_W'(5);
    bias  = 12'hFFF;
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    in_a = 4'd1; in_b = 4'd1;
    tick();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check1("midrst_in_ready", in_ready, 1'b0);
    check1("midrst_out_valid", out_valid, 1'b0);
    check("midrst_out_acc", out_acc, 12'h000);
    check1("midrst_out_ovf", out_ovf, 1'b0);
    check1("midrst_busy", busy, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    pa[0] = 4'd7; pb[0] = 4'd6;
    pa[1] = 4'd5; pb[1] = 4'd9;
    do_job("post_rst", 12'h100, 2, 0, 0);

    // Randomized jobs
    for (int j = 0; j < 25; j++) begin
      int n;
      n = int'($urandom_range(0, 15));
      for (int i = 0; i < 16; i++) begin
        pa[i] = 4'($urandom);
        pb[i] = 4'($urandom);
      end
      do_job("rand", 12'($urandom), n, 1, int'($urandom_range(0, 3)));
      if (($urandom & 1) != 0) tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
